// File: rtl/dpram_ctrl_pkg.sv
// ============================================================================
// dpram_ctrl_pkg : shared constants and FSM state encoding for dpram_access_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

package dpram_ctrl_pkg;

    localparam int DEF_ADDR_W = 4;
    localparam int DEF_DATA_W = 8;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RD_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP    = 2'd2;

endpackage

`default_nettype wire

// File: rtl/dpram_access_ctrl_if.sv
// ============================================================================
// dpram_access_ctrl_if : client request/response and RAM-side signal bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface dpram_access_ctrl_if
    import dpram_ctrl_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);

    logic              req_valid_a, req_ready_a, req_we_a;
    logic [ADDR_W-1:0] req_addr_a;
    logic [DATA_W-1:0] req_wdata_a;
    logic              rsp_valid_a, rsp_ready_a;
    logic [DATA_W-1:0] rsp_data_a;

    logic              req_valid_b, req_ready_b, req_we_b;
    logic [ADDR_W-1:0] req_addr_b;
    logic [DATA_W-1:0] req_wdata_b;
    logic              rsp_valid_b, rsp_ready_b;
    logic [DATA_W-1:0] rsp_data_b;

    logic              mem_wr_enA, mem_wr_enB;
    logic [ADDR_W-1:0] mem_addr_A, mem_addr_B;
    logic [DATA_W-1:0] mem_wr_dataA, mem_wr_dataB;
    logic [DATA_W-1:0] mem_rd_dataA, mem_rd_dataB;

    // Environment side: clients plus the RAM.
    modport master (
        output req_valid_a, req_we_a, req_addr_a, req_wdata_a, rsp_ready_a,
        input  req_ready_a, rsp_valid_a, rsp_data_a,
        output req_valid_b, req_we_b, req_addr_b, req_wdata_b, rsp_ready_b,
        input  req_ready_b, rsp_valid_b, rsp_data_b,
        input  mem_wr_enA, mem_wr_enB, mem_addr_A, mem_addr_B,
        input  mem_wr_dataA, mem_wr_dataB,
        output mem_rd_dataA, mem_rd_dataB
    );

    modport slave (
        input  req_valid_a, req_we_a, req_addr_a, req_wdata_a, rsp_ready_a,
        output req_ready_a, rsp_valid_a, rsp_data_a,
        input  req_valid_b, req_we_b, req_addr_b, req_wdata_b, rsp_ready_b,
        output req_ready_b, rsp_valid_b, rsp_data_b,
        output mem_wr_enA, mem_wr_enB, mem_addr_A, mem_addr_B,
        output mem_wr_dataA, mem_wr_dataB,
        input  mem_rd_dataA, mem_rd_dataB
    );

endinterface

`default_nettype wire

// File: rtl/dpram_port_fsm.sv
// ============================================================================
// dpram_port_fsm : per-port IDLE/RD_WAIT/RESP sequencer with response register
// Rev 1.0
// ============================================================================
`default_nettype none

module dpram_port_fsm
    import dpram_ctrl_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              i_req_valid,
    input  wire logic              i_req_we,
    input  wire logic              i_rsp_ready,
    input  wire logic              i_stall,
    input  wire logic [DATA_W-1:0] i_mem_rd_data,
    output logic                   o_req_ready,
    output logic                   o_fire,
    output logic                   o_rsp_valid,
    output logic [DATA_W-1:0]      o_rsp_data
);

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

    // Ready is gated by rst_n so nothing can fire while reset is held.
    always_comb begin
        o_req_ready = 1'b0;
        if (rst_n && !i_stall) begin
            o_req_ready = (state_q == ST_IDLE) || ((state_q == ST_RESP) && i_rsp_ready);
        end
    end

    assign o_fire      = i_req_valid && o_req_ready;
    assign o_rsp_valid = (state_q == ST_RESP);
    assign o_rsp_data  = rsp_data_q;

    always_comb begin
        state_d    = state_q;
        rsp_data_d = rsp_data_q;
        case (state_q)
            ST_IDLE: begin
                if (o_fire && !i_req_we) state_d = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                state_d    = ST_RESP;
                rsp_data_d = i_mem_rd_data;
            end
            ST_RESP: begin
                if (i_rsp_ready) state_d = (o_fire && !i_req_we) ? ST_RD_WAIT : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            rsp_data_q <= rsp_data_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/dpram_access_ctrl.sv
// ============================================================================
// dpram_access_ctrl : two-client dual-port RAM front end with B-side write stall
// Rev 1.0
// ============================================================================
`default_nettype none

module dpram_access_ctrl
    import dpram_ctrl_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    dpram_access_ctrl_if.slave bus,
    output logic [7:0]         conflict_cnt
);

    logic              fire_a, fire_b;
    logic              stall_b;
    logic [ADDR_W-1:0] addr_a, addr_b;
    logic [7:0]        cnt_q, cnt_d;

    assign addr_a = bus.req_addr_a;
    assign addr_b = bus.req_addr_b;

    // A wins a same-address write collision; B is held off and retries.
    assign stall_b = fire_a && bus.req_we_a && bus.req_valid_b && bus.req_we_b
                     && (addr_a == addr_b);

    dpram_port_fsm #(.DATA_W(DATA_W)) u_port_a (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_req_valid  (bus.req_valid_a),
        .i_req_we     (bus.req_we_a),
        .i_rsp_ready  (bus.rsp_ready_a),
        .i_stall      (1'b0),
        .i_mem_rd_data(bus.mem_rd_dataA),
        .o_req_ready  (bus.req_ready_a),
        .o_fire       (fire_a),
        .o_rsp_valid  (bus.rsp_valid_a),
        .o_rsp_data   (bus.rsp_data_a)
    );

    dpram_port_fsm #(.DATA_W(DATA_W)) u_port_b (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_req_valid  (bus.req_valid_b),
        .i_req_we     (bus.req_we_b),
        .i_rsp_ready  (bus.rsp_ready_b),
        .i_stall      (stall_b),
        .i_mem_rd_data(bus.mem_rd_dataB),
        .o_req_ready  (bus.req_ready_b),
        .o_fire       (fire_b),
        .o_rsp_valid  (bus.rsp_valid_b),
        .o_rsp_data   (bus.rsp_data_b)
    );

    assign bus.mem_addr_A   = bus.req_addr_a;
    assign bus.mem_addr_B   = bus.req_addr_b;
    assign bus.mem_wr_dataA = bus.req_wdata_a;
    assign bus.mem_wr_dataB = bus.req_wdata_b;
    assign bus.mem_wr_enA   = fire_a && bus.req_we_a;
    assign bus.mem_wr_enB   = fire_b && bus.req_we_b;

    always_comb begin
        cnt_d = cnt_q;
        if (stall_b && (cnt_q != 8'hFF)) cnt_d = cnt_q + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= 8'd0;
        else        cnt_q <= cnt_d;
    end

    assign conflict_cnt = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_dpram_access_ctrl.sv
// ============================================================================
// tb_dpram_access_ctrl : directed vector table plus multi-cycle sequences
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_dpram_access_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] conflict_cnt;
    int         checks   = 0;
    int         failures = 0;

    dpram_access_ctrl_if bus ();

    dpram_access_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    // RAM model: registered read, old data on same-address read/write.
    logic [7:0] ram [16];
    always @(posedge clk) begin
        if (bus.mem_wr_enA) ram[bus.mem_addr_A] <= bus.mem_wr_dataA;
        if (bus.mem_wr_enB) ram[bus.mem_addr_B] <= bus.mem_wr_dataB;
        bus.mem_rd_dataA <= ram[bus.mem_addr_A];
        bus.mem_rd_dataB <= ram[bus.mem_addr_B];
    end

    typedef struct packed {
        logic       va, wea;
        logic [3:0] aa;
        logic [7:0] da;
        logic       vb, web;
        logic [3:0] ab;
        logic [7:0] db;
        logic       rdy_b, en_a, en_b;
        logic [7:0] cnt;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.req_valid_a = 1'b0; bus.req_we_a = 1'b0; bus.req_addr_a = '0; bus.req_wdata_a = '0;
        bus.req_valid_b = 1'b0; bus.req_we_b = 1'b0; bus.req_addr_b = '0; bus.req_wdata_b = '0;
        bus.rsp_ready_a = 1'b1; bus.rsp_ready_b = 1'b1;
    endtask

    task automatic do_read(input bit pb, input logic [3:0] addr, input logic [7:0] exp,
                           input string nm);
        if (!pb) begin
            bus.req_valid_a = 1'b1; bus.req_we_a = 1'b0; bus.req_addr_a = addr;
        end else begin
            bus.req_valid_b = 1'b1; bus.req_we_b = 1'b0; bus.req_addr_b = addr;
        end
        mid();
        chk({nm, "_accept"}, pb ? bus.req_ready_b : bus.req_ready_a, 1);
        step();
        bus.req_valid_a = 1'b0; bus.req_valid_b = 1'b0;
        mid();
        chk({nm, "_latency"}, pb ? bus.rsp_valid_b : bus.rsp_valid_a, 0);
        step();
        mid();
        chk({nm, "_valid"}, pb ? bus.rsp_valid_b : bus.rsp_valid_a, 1);
        chk({nm, "_data"}, pb ? bus.rsp_data_b : bus.rsp_data_a, exp);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        //            va wea aa    da     vb web ab    db     rdy en_a en_b cnt
        vecs[0] = '{1'b1, 1'b1, 4'd7,  8'h11, 1'b1, 1'b1, 4'd7,  8'h22, 1'b0, 1'b1, 1'b0, 8'd1};
        vecs[1] = '{1'b1, 1'b1, 4'd7,  8'h11, 1'b1, 1'b1, 4'd8,  8'h33, 1'b1, 1'b1, 1'b1, 8'd2};
        vecs[2] = '{1'b0, 1'b1, 4'd7,  8'h00, 1'b1, 1'b1, 4'd7,  8'h44, 1'b1, 1'b0, 1'b1, 8'd2};
        vecs[3] = '{1'b1, 1'b1, 4'd2,  8'h55, 1'b0, 1'b1, 4'd2,  8'h00, 1'b1, 1'b1, 1'b0, 8'd2};
        vecs[4] = '{1'b1, 1'b1, 4'd15, 8'h66, 1'b1, 1'b1, 4'd15, 8'h77, 1'b0, 1'b1, 1'b0, 8'd2};
        vecs[5] = '{1'b1, 1'b1, 4'd0,  8'h01, 1'b1, 1'b1, 4'd0,  8'h02, 1'b0, 1'b1, 1'b0, 8'd3};
        vecs[6] = '{1'b0, 1'b0, 4'd0,  8'h00, 1'b0, 1'b0, 4'd0,  8'h00, 1'b1, 1'b0, 1'b0, 8'd4};

        // Reset hold with requests pending
        idle_inputs();
        rst_n = 1'b0;
        bus.req_valid_a = 1'b1; bus.req_we_a = 1'b1; bus.req_addr_a = 4'd1;
        bus.req_valid_b = 1'b1;
        step(); step();
        mid();
        chk("rst_ready_a", bus.req_ready_a, 0);
        chk("rst_ready_b", bus.req_ready_b, 0);
        chk("rst_wr_en_a", bus.mem_wr_enA, 0);
        chk("rst_rsp_valid_a", bus.rsp_valid_a, 0);
        chk("rst_rsp_data_b", bus.rsp_data_b, 0);
        chk("rst_cnt", conflict_cnt, 0);
        step();
        idle_inputs();
        rst_n = 1'b1;
        mid();
        chk("rel_ready_a", bus.req_ready_a, 1);
        chk("rel_ready_b", bus.req_ready_b, 1);
        step();

        // Write-write conflict on address 7, B retried next cycle
        bus.req_valid_a = 1'b1; bus.req_we_a = 1'b1; bus.req_addr_a = 4'd7; bus.req_wdata_a = 8'h11;
        bus.req_valid_b = 1'b1; bus.req_we_b = 1'b1; bus.req_addr_b = 4'd7; bus.req_wdata_b = 8'h22;
        mid();
        chk("ww_ready_b", bus.req_ready_b, 0);
        chk("ww_wr_en_b", bus.mem_wr_enB, 0);
        chk("ww_wr_en_a", bus.mem_wr_enA, 1);
        step();
        bus.req_valid_a = 1'b0;
        mid();
        chk("ww_retry_ready_b", bus.req_ready_b, 1);
        chk("ww_retry_wr_en_b", bus.mem_wr_enB, 1);
        chk("ww_cnt", conflict_cnt, 1);
        step();
        idle_inputs();
        do_read(1'b0, 4'd7, 8'h22, "ww_final");

        // Table-driven single-cycle vectors
        for (int i = 0; i < 7; i++) begin
            bus.req_valid_a = vecs[i].va; bus.req_we_a = vecs[i].wea;
            bus.req_addr_a  = vecs[i].aa; bus.req_wdata_a = vecs[i].da;
            bus.req_valid_b = vecs[i].vb; bus.req_we_b = vecs[i].web;
            bus.req_addr_b  = vecs[i].ab; bus.req_wdata_b = vecs[i].db;
            mid();
            chk($sformatf("vec%0d_ready_b", i), bus.req_ready_b, vecs[i].rdy_b);
            chk($sformatf("vec%0d_wr_en_a", i), bus.mem_wr_enA, vecs[i].en_a);
            chk($sformatf("vec%0d_wr_en_b", i), bus.mem_wr_enB, vecs[i].en_b);
            chk($sformatf("vec%0d_cnt", i), conflict_cnt, vecs[i].cnt);
            chk($sformatf("vec%0d_addr_b", i), bus.mem_addr_B, vecs[i].ab);
            chk($sformatf("vec%0d_wdata_a", i), bus.mem_wr_dataA, vecs[i].da);
            step();
        end
        idle_inputs();

        // Write then read on A
        bus.req_valid_a = 1'b1; bus.req_we_a = 1'b1; bus.req_addr_a = 4'd3; bus.req_wdata_a = 8'hA5;
        mid();
        chk("wr3_wr_en_a", bus.mem_wr_enA, 1);
        chk("wr3_addr_a", bus.mem_addr_A, 3);
        step();
        idle_inputs();
        do_read(1'b0, 4'd3, 8'hA5, "wr_rd");

        // Opposite-port read/write collision on address 5
        bus.req_valid_a = 1'b1; bus.req_we_a = 1'b1; bus.req_addr_a = 4'd5; bus.req_wdata_a = 8'h0F;
        step();
        bus.req_we_a = 1'b0;
        bus.req_valid_b = 1'b1; bus.req_we_b = 1'b1; bus.req_addr_b = 4'd5; bus.req_wdata_b = 8'hF0;
        mid();
        chk("rw_ready_a", bus.req_ready_a, 1);
        chk("rw_ready_b", bus.req_ready_b, 1);
        chk("rw_wr_en_b", bus.mem_wr_enB, 1);
        step();
        idle_inputs();
        step();
        mid();
        chk("rw_rsp_valid_a", bus.rsp_valid_a, 1);
        chk("rw_old_data_a", bus.rsp_data_a, 8'h0F);
        step();
        do_read(1'b0, 4'd5, 8'hF0, "rw_after");

        // Both ports read the same address
        bus.req_valid_a = 1'b1; bus.req_addr_a = 4'd5;
        bus.req_valid_b = 1'b1; bus.req_addr_b = 4'd5;
        mid();
        chk("rr_ready_a", bus.req_ready_a, 1);
        chk("rr_ready_b", bus.req_ready_b, 1);
        step();
        idle_inputs();
        step();
        mid();
        chk("rr_data_a", bus.rsp_data_a, 8'hF0);
        chk("rr_valid_b", bus.rsp_valid_b, 1);
        chk("rr_data_b", bus.rsp_data_b, 8'hF0);
        step();

        // Backpressure on B, then back-to-back accept
        bus.rsp_ready_b = 1'b0;
        bus.req_valid_b = 1'b1; bus.req_we_b = 1'b0; bus.req_addr_b = 4'd3;
        mid();
        chk("bp_accept", bus.req_ready_b, 1);
        step();
        bus.req_addr_b = 4'd2;
        step();
        for (int k = 0; k < 4; k++) begin
            mid();
            chk($sformatf("bp%0d_valid", k), bus.rsp_valid_b, 1);
            chk($sformatf("bp%0d_data", k), bus.rsp_data_b, 8'hA5);
            chk($sformatf("bp%0d_ready", k), bus.req_ready_b, 0);
            step();
        end
        bus.rsp_ready_b = 1'b1;
        mid();
        chk("bp_b2b_ready", bus.req_ready_b, 1);
        chk("bp_b2b_valid", bus.rsp_valid_b, 1);
        step();
        bus.req_valid_b = 1'b0;
        mid();
        chk("bp_b2b_wait", bus.rsp_valid_b, 0);
        step();
        mid();
        chk("bp_b2b_valid2", bus.rsp_valid_b, 1);
        chk("bp_b2b_data2", bus.rsp_data_b, 8'h55);
        step();
        idle_inputs();

        // Reset with A in RESP and B in RD_WAIT
        bus.rsp_ready_a = 1'b0;
        bus.req_valid_a = 1'b1; bus.req_addr_a = 4'd3;
        step();
        bus.req_valid_a = 1'b0;
        bus.req_valid_b = 1'b1; bus.req_addr_b = 4'd5;
        step();
        bus.req_valid_b = 1'b0;
        mid();
        chk("mr_pre_valid_a", bus.rsp_valid_a, 1);
        chk("mr_pre_cnt", conflict_cnt, 4);
        #1 rst_n = 1'b0;
        #1;
        chk("mr_valid_a", bus.rsp_valid_a, 0);
        chk("mr_data_a", bus.rsp_data_a, 0);
        chk("mr_cnt", conflict_cnt, 0);
        step(); step();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            mid();
            chk($sformatf("mr_post%0d_valid_a", k), bus.rsp_valid_a, 0);
            chk($sformatf("mr_post%0d_valid_b", k), bus.rsp_valid_b, 0);
            if (k == 0) chk("mr_post_ready_a", bus.req_ready_a, 1);
            step();
        end
        idle_inputs();

        // Conflict counter saturation
        bus.req_valid_a = 1'b1; bus.req_we_a = 1'b1; bus.req_addr_a = 4'd9; bus.req_wdata_a = 8'hAA;
        bus.req_valid_b = 1'b1; bus.req_we_b = 1'b1; bus.req_addr_b = 4'd9; bus.req_wdata_b = 8'hBB;
        for (int i = 0; i < 300; i++) begin
            mid();
            if (i == 0)   chk("sat_ready_b", bus.req_ready_b, 0);
            if (i == 1)   chk("sat_cnt1", conflict_cnt, 1);
            if (i == 254) chk("sat_cnt254", conflict_cnt, 254);
            if (i == 255) chk("sat_cnt255", conflict_cnt, 255);
            if (i == 299) chk("sat_cnt299", conflict_cnt, 255);
            step();
        end
        mid();
        chk("sat_final", conflict_cnt, 255);
        step();
        idle_inputs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
